// File: rtl/controlador_busqueda_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, halt encoding and FSM states.
package controlador_busqueda_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] HLT_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/controlador_busqueda.sv
// Instruction fetch controller: drives the synchronous instruction memory address,
// presents the fetched word to decode, and handles stall, redirect and halt.
module controlador_busqueda
  import controlador_busqueda_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [DATA_W-1:0] instruccion,
  output logic [ADDR_W-1:0] direccion,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [31:0]       count_q, count_d;

  // State register; reset aborts any fetch in flight, including HALT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StInit;
      pc_q       <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
    end
  end

  // Next-state and memory address; priority in RUN is redirect > stall > accept.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    count_d    = count_q;
    direccion  = instr_pc_q;

    unique case (state_q)
      StInit: begin
        // Word 0 is requested now and appears on instruccion next cycle.
        direccion  = '0;
        pc_d       = ADDR_W'(1);
        instr_pc_d = '0;
        valid_d    = 1'b1;
        state_d    = StRun;
      end
      StRun: begin
        if (redirect) begin
          direccion  = redirect_target;
          instr_pc_d = redirect_target;
          pc_d       = redirect_target + 1'b1;
        end else if (stall) begin
          // Re-read the presented word so instruccion stays stable.
          direccion = instr_pc_q;
        end else begin
          count_d = count_q + 32'd1;
          if (instruccion != HLT_WORD) begin
            direccion  = pc_q;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 1'b1;
          end else begin
            direccion = instr_pc_q;
            valid_d   = 1'b0;
            halted_d  = 1'b1;
            state_d   = StHalt;
          end
        end
      end
      StHalt: begin
        direccion = instr_pc_q;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  assign instr_out   = instruccion;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_controlador_busqueda.sv
// Scoreboard bench for controlador_busqueda with a behavioural synchronous instruction memory.
module tb_controlador_busqueda;
  import controlador_busqueda_pkg::*;

  logic              clk;
  logic              reset_n;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic [DATA_W-1:0] instruccion;
  logic [ADDR_W-1:0] direccion;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              halted;
  logic [31:0]       fetch_count;

  logic [DATA_W-1:0] mem [1024];

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       cnt;
    logic              h;
    logic [ADDR_W-1:0] dir;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  controlador_busqueda dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instruccion     (instruccion),
    .direccion       (direccion),
    .instr_valid     (instr_valid),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency instruction memory.
  always @(posedge clk) instruccion <= mem[direccion];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: whenever the DUT presents a word (or is halted), pop and compare.
  always @(negedge clk) begin
    if (reset_n && (instr_valid || halted)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: pc=%0d valid=%0b halted=%0b with empty scoreboard",
                 instr_pc, instr_valid, halted);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("instr_valid", 32'(instr_valid), 32'(e.v));
        chk("instr_pc", 32'(instr_pc), 32'(e.pc));
        chk("instr_out", instr_out, mem[e.pc]);
        chk("fetch_count", fetch_count, e.cnt);
        chk("halted", 32'(halted), 32'(e.h));
        chk("direccion", 32'(direccion), 32'(e.dir));
      end
    end
  end

  // One cycle of stimulus plus its expected outputs; called at posedge+1.
  task automatic cyc(input logic s, input logic r, input logic [ADDR_W-1:0] t,
                     input logic v, input logic [ADDR_W-1:0] pc, input logic [31:0] cnt,
                     input logic h, input logic [ADDR_W-1:0] dir);
    exp_t e;
    stall           = s;
    redirect        = r;
    redirect_target = t;
    e.v = v; e.pc = pc; e.cnt = cnt; e.h = h; e.dir = dir;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge, then INIT for one cycle.
  task automatic do_reset();
    reset_n  = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    #2;
    chk("rst_direccion", 32'(direccion), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_count", fetch_count, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("init_direccion", 32'(direccion), 32'd0);
    chk("init_instr_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h8000_0000 | 32'(i);
    mem[4]  = HLT_WORD;
    mem[50] = HLT_WORD;

    // Straight-line fetch to a HLT at word 4; HALT ignores stall and redirect.
    do_reset();
    //  s     r     tgt  v     pc  cnt  h     dir
    cyc(1'b0, 1'b0, 0,   1'b1, 0,  0,   1'b0, 1);
    cyc(1'b0, 1'b0, 0,   1'b1, 1,  1,   1'b0, 2);
    cyc(1'b0, 1'b0, 0,   1'b1, 2,  2,   1'b0, 3);
    cyc(1'b0, 1'b0, 0,   1'b1, 3,  3,   1'b0, 4);
    cyc(1'b0, 1'b0, 0,   1'b1, 4,  4,   1'b0, 4);
    cyc(1'b0, 1'b0, 0,   1'b0, 4,  5,   1'b1, 4);
    cyc(1'b0, 1'b1, 9,   1'b0, 4,  5,   1'b1, 4);
    cyc(1'b1, 1'b0, 0,   1'b0, 4,  5,   1'b1, 4);

    // Reset while halted, then a 3-cycle stall at pc 2.
    do_reset();
    cyc(1'b0, 1'b0, 0,   1'b1, 0,  0,   1'b0, 1);
    cyc(1'b0, 1'b0, 0,   1'b1, 1,  1,   1'b0, 2);
    cyc(1'b1, 1'b0, 0,   1'b1, 2,  2,   1'b0, 2);
    cyc(1'b1, 1'b0, 0,   1'b1, 2,  2,   1'b0, 2);
    cyc(1'b1, 1'b0, 0,   1'b1, 2,  2,   1'b0, 2);
    cyc(1'b0, 1'b0, 0,   1'b1, 2,  2,   1'b0, 3);
    cyc(1'b0, 1'b0, 0,   1'b1, 3,  3,   1'b0, 4);

    // Redirects: to 32, redirect+stall to 7, wrap at 1023, HLT word under stall/redirect.
    do_reset();
    cyc(1'b0, 1'b0, 0,    1'b1, 0,    0, 1'b0, 1);
    cyc(1'b0, 1'b0, 0,    1'b1, 1,    1, 1'b0, 2);
    cyc(1'b0, 1'b1, 32,   1'b1, 2,    2, 1'b0, 32);
    cyc(1'b0, 1'b0, 0,    1'b1, 32,   2, 1'b0, 33);
    cyc(1'b1, 1'b1, 7,    1'b1, 33,   3, 1'b0, 7);
    cyc(1'b0, 1'b1, 1023, 1'b1, 7,    3, 1'b0, 1023);
    cyc(1'b0, 1'b0, 0,    1'b1, 1023, 3, 1'b0, 0);
    cyc(1'b0, 1'b0, 0,    1'b1, 0,    4, 1'b0, 1);
    cyc(1'b0, 1'b1, 50,   1'b1, 1,    5, 1'b0, 50);
    cyc(1'b1, 1'b0, 0,    1'b1, 50,   5, 1'b0, 50);
    cyc(1'b0, 1'b1, 60,   1'b1, 50,   5, 1'b0, 60);
    cyc(1'b0, 1'b0, 0,    1'b1, 60,   5, 1'b0, 61);
    cyc(1'b0, 1'b0, 0,    1'b1, 61,   6, 1'b0, 62);

    // Reset mid-RUN; fetch restarts at address 0.
    do_reset();
    cyc(1'b0, 1'b0, 0,   1'b1, 0,  0,   1'b0, 1);
    cyc(1'b0, 1'b0, 0,   1'b1, 1,  1,   1'b0, 2);

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
